// File: rtl/demux3_stream.sv
// Purpose : steer one signed word stream into one of three one-entry lane
//           registers. The lane comes from sel, or from a round-robin pointer
//           when auto=1.
// Latency : 1 cycle from accept to out_valid/outK.
// Backpr. : in_ready = target lane empty or draining this cycle, so a full
//           lane that is draining still accepts (pass-through).
//
// Optional macro DEMUX3_BCAST_EN: with auto=0 and sel=11 the word is
// broadcast to all three lanes. in_ready is then the AND of the three
// lane-free terms. Without the macro, sel=11 selects lane2.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    producer handshake; in_data is the signed n-bit word
//   sel, auto, clear     lane select, round-robin enable, pointer clear (sync)
//   out_valid/out_ready  per-lane handshake, one bit per lane
//   out0, out1, out2     lane data registers
//   ptr                  round-robin pointer (00/01/10)
module demux3_stream #(
  parameter int n = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [n-1:0] in_data,
  input  logic [1:0]          sel,
  input  logic                auto,
  input  logic                clear,
  output logic [2:0]          out_valid,
  input  logic [2:0]          out_ready,
  output logic signed [n-1:0] out0,
  output logic signed [n-1:0] out1,
  output logic signed [n-1:0] out2,
  output logic [1:0]          ptr
);

  typedef enum logic [1:0] {
    L0 = 2'b00,
    L1 = 2'b01,
    L2 = 2'b10
  } ptr_state_t;

  ptr_state_t state;

  logic [1:0] tgt;
  logic [2:0] lane_free;
  logic [2:0] load;
  logic       bcast;
  logic       accept;

  // A lane can take a word if it is empty or is handing its word off this cycle.
  assign lane_free = ~out_valid | out_ready;

  always_comb begin
    tgt = 2'd0;
    if (auto) begin
      tgt = state;
    end else begin
      case (sel)
        2'b00:   tgt = 2'd0;
        2'b01:   tgt = 2'd1;
        default: tgt = 2'd2;
      endcase
    end
  end

`ifdef DEMUX3_BCAST_EN
  assign bcast = !auto && (sel == 2'b11);
`else
  assign bcast = 1'b0;
`endif

  // Held low through reset so the producer never sees a spurious accept.
  assign in_ready = rst_n && (bcast ? (&lane_free) : lane_free[tgt]);
  assign accept   = in_valid && in_ready;

  always_comb begin
    load = 3'b000;
    if (accept) begin
      load = bcast ? 3'b111 : (3'b001 << tgt);
    end
  end

  // Lane valid: a reload wins over a drain in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 3'b000;
    end else begin
      out_valid <= load | (out_valid & ~out_ready);
    end
  end

  // Lane data only changes on a load. It is held after a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0 <= '0;
      out1 <= '0;
      out2 <= '0;
    end else begin
      if (load[0]) out0 <= in_data;
      if (load[1]) out1 <= in_data;
      if (load[2]) out2 <= in_data;
    end
  end

  // Round-robin pointer. clear has priority over an auto-mode advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= L0;
    end else if (clear) begin
      state <= L0;
    end else if (accept && auto) begin
      case (state)
        L0:      state <= L1;
        L1:      state <= L2;
        default: state <= L0;
      endcase
    end
  end

  assign ptr = state;

endmodule

// File: tb/tb_demux3_stream.sv
module tb_demux3_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] sel;
  logic       auto;
  logic       clear;
  logic [2:0] out_valid;
  logic [2:0] out_ready;
  logic [7:0] out0;
  logic [7:0] out1;
  logic [7:0] out2;
  logic [1:0] ptr;

  int n_checks = 0;
  int n_pass   = 0;

  demux3_stream #(.n(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel       (sel),
    .auto      (auto),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .ptr       (ptr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sample point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lane(input int k);
    case (k)
      0:       return out0;
      1:       return out1;
      default: return out2;
    endcase
  endfunction

  logic [7:0] vals [4];

  initial begin
    vals[0] = 8'd10; vals[1] = 8'd20; vals[2] = 8'd30; vals[3] = 8'd40;
    rst_n = 1'b1; in_valid = 1'b0; in_data = 8'h00; sel = 2'b00;
    auto = 1'b0; clear = 1'b0; out_ready = 3'b000;
    #2 rst_n = 1'b0;
    in_valid = 1'b1; sel = 2'b01; in_data = 8'hFB;   // -5
    #1;
    check("rst_ov",  32'(out_valid), 32'd0);
    check("rst_ptr", 32'(ptr), 32'd0);
    check("rst_d0",  32'(out0), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("t1_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t1_ov", 32'(out_valid), 32'b010);
    check("t1_d1", 32'(out1), 32'hFB);
    check("t1_d0", 32'(out0), 32'd0);
    check("t1_d2", 32'(out2), 32'd0);

    // Full lane1 blocks, then pass-through reload once it drains.
    in_valid = 1'b1; in_data = 8'd7;
    #1;
    check("t2_blk", 32'(in_ready), 32'd0);
    tick();
    check("t2_hold", 32'(out1), 32'hFB);
    out_ready = 3'b010;
    #1;
    check("t2_pass", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t2_d1", 32'(out1), 32'd7);
    check("t2_ov", 32'(out_valid), 32'b010);
    tick();
    check("t2_drain", 32'(out_valid), 32'b000);
    check("t2_keep", 32'(out1), 32'd7);

    // Round-robin, back-to-back at full rate.
    auto = 1'b1; out_ready = 3'b111;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      #1;
      check($sformatf("rr_rdy%0d", i), 32'(in_ready), 32'd1);
      check($sformatf("rr_ptr%0d", i), 32'(ptr), 32'(i % 3));
      tick();
      check($sformatf("rr_dat%0d", i), 32'(lane(i % 3)), 32'(vals[i]));
      check($sformatf("rr_ov%0d", i), 32'(out_valid), 32'(3'b001 << (i % 3)));
    end
    check("rr_ptr_end", 32'(ptr), 32'd1);

    // auto=0 leaves the pointer alone.
    auto = 1'b0; sel = 2'b00; in_data = 8'd55;
    tick();
    check("man_d0", 32'(out0), 32'd55);
    check("man_ptr", 32'(ptr), 32'd1);

    // clear, then 1,2 then clear together with accept of 3.
    in_valid = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_ptr", 32'(ptr), 32'd0);
    auto = 1'b1; in_valid = 1'b1; in_data = 8'd1;
    tick();
    in_data = 8'd2;
    tick();
    check("clr_ptr2", 32'(ptr), 32'd2);
    in_data = 8'd3; clear = 1'b1;
    tick();
    in_valid = 1'b0; clear = 1'b0;
    check("clr_d2", 32'(out2), 32'd3);
    check("clr_ptr3", 32'(ptr), 32'd0);

    // Fill all lanes with ptr left at 10, then reset mid-cycle.
    out_ready = 3'b000; in_valid = 1'b1; in_data = 8'd11;
    tick();
    in_data = 8'd22;
    tick();
    auto = 1'b0; sel = 2'b10; in_data = 8'd33;
    tick();
    in_valid = 1'b0;
    check("full_ov", 32'(out_valid), 32'b111);
    check("full_ptr", 32'(ptr), 32'd2);
    check("full_d1", 32'(out1), 32'd22);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ov",  32'(out_valid), 32'd0);
    check("arst_ptr", 32'(ptr), 32'd0);
    check("arst_d0",  32'(out0), 32'd0);
    check("arst_d1",  32'(out1), 32'd0);
    check("arst_d2",  32'(out2), 32'd0);
    tick();
    #2 rst_n = 1'b1;

    // Broadcast stimulus: lane0 full, sel=11, data=-128.
    tick();
    sel = 2'b00; in_valid = 1'b1; in_data = 8'd1;
    tick();
    sel = 2'b11; in_data = 8'h80;   // -128
    #1;
`ifdef DEMUX3_BCAST_EN
    check("bc_blk", 32'(in_ready), 32'd0);
`else
    check("bc_blk", 32'(in_ready), 32'd1);
`endif
    out_ready = 3'b001;
    #1;
    check("bc_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
`ifdef DEMUX3_BCAST_EN
    check("bc_ov", 32'(out_valid), 32'b111);
    check("bc_d0", 32'(out0), 32'h80);
    check("bc_d1", 32'(out1), 32'h80);
`else
    check("bc_ov", 32'(out_valid), 32'b100);
    check("bc_d0", 32'(out0), 32'd1);
    check("bc_d1", 32'(out1), 32'd0);
`endif
    check("bc_d2", 32'(out2), 32'h80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
